// File: rtl/risc5_wb_pkg.sv
// Shared types and sizes for the write-back sequencer and its scoreboard.
package risc5_wb_pkg;
  localparam int REG_W    = 4;
  localparam int NREGS    = 16;
  localparam int DATA_W   = 32;
  localparam int STARVE_W = 8;

  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/risc5_scoreboard.sv
// Pending-register scoreboard: tracks destinations of outstanding long
// operations, counts them, answers hazard lookups and flags protocol errors.
// All strobes arrive already qualified with the clock enable.
module risc5_scoreboard
  import risc5_wb_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             inc_i,     // long accept
  input  logic             set_i,     // long accept that writes a register
  input  reg_idx_t         set_rd_i,
  input  logic             hs_i,      // long result handshake
  input  reg_idx_t         hs_rd_i,
  input  logic             alu_wr_i,
  input  reg_idx_t         alu_rd_i,
  input  reg_idx_t         qa_i,
  input  reg_idx_t         qb_i,
  input  reg_idx_t         qd_i,
  output logic             pend_a_o,
  output logic             pend_b_o,
  output logic             pend_d_o,
  output logic             full_o,
  output logic [REG_W-1:0] outstanding_o,
  output logic             err_o
);
  logic [NREGS-1:0] pend_q, pend_d;
  logic [REG_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign full_o        = (cnt_q == REG_W'(MAX_OUT));
  assign pend_a_o      = pend_q[qa_i];
  assign pend_b_o      = pend_q[qb_i];
  assign pend_d_o      = pend_q[qd_i];
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Next state: set on long accept, clear on handshake, count both ways.
  always_comb begin
    pend_d = pend_q;
    if (set_i) pend_d[set_rd_i] = 1'b1;
    if (hs_i)  pend_d[hs_rd_i]  = 1'b0;
    cnt_d = cnt_q;
    // A stray handshake (already an error) must not wrap the count.
    if (inc_i && !hs_i)                    cnt_d = cnt_q + 1'b1;
    else if (!inc_i && hs_i && cnt_q != 0) cnt_d = cnt_q - 1'b1;
    err_d = err_q
          | (hs_i & ~pend_q[hs_rd_i])
          | (alu_wr_i & pend_q[alu_rd_i])
          | (inc_i & full_o);
  end

  // Scoreboard state register, frozen while the clock enable is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (ce_i) begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: rtl/risc5_wb_sequencer.sv
// Write-back sequencer: arbitrates ALU and long-unit results onto the
// register-file write port and stalls issue on hazards against pending
// long operations. Optional macro RISC5_WB_FWD_EN lets a same-cycle long
// result satisfy a stalled source and exposes fwd_a/fwd_b.
module risc5_wb_sequencer
  import risc5_wb_pkg::*;
#(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_ra,
  input  logic [REG_W-1:0]  iss_rb,
  input  logic [REG_W-1:0]  iss_rd,
  input  logic              iss_use_ra,
  input  logic              iss_use_rb,
  input  logic              iss_use_rd,
  input  logic              iss_long,
  output logic              iss_stall,
  input  logic              alu_wr,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lng_valid,
  input  logic [REG_W-1:0]  lng_rd,
  input  logic [DATA_W-1:0] lng_data,
  output logic              lng_ready,
  output logic              rf_wr,
  output logic [REG_W-1:0]  rf_wno,
  output logic [DATA_W-1:0] rf_din,
  output logic [REG_W-1:0]  outstanding,
  output logic              err
`ifdef RISC5_WB_FWD_EN
  ,output logic             fwd_a
  ,output logic             fwd_b
`endif
);
  logic                alu_go, lng_hs, accept;
  logic                pend_a, pend_b, pend_d, full;
  logic                haz_a, haz_b, haz_d, throttle;
  logic [STARVE_W-1:0] starve_q, starve_d;

  // ALU wins the port; long unit only gets it on ALU-free cycles.
  assign alu_go    = rst & ce & alu_wr;
  assign lng_ready = ce & ~alu_wr & rst;
  assign lng_hs    = lng_valid & lng_ready;
  assign rf_wr     = alu_go | lng_hs;

  // Write-port mux, zeroed when nothing is written.
  always_comb begin
    rf_wno = '0;
    rf_din = '0;
    if (alu_go) begin
      rf_wno = alu_rd;
      rf_din = alu_data;
    end else if (lng_hs) begin
      rf_wno = lng_rd;
      rf_din = lng_data;
    end
  end

  risc5_scoreboard #(.MAX_OUT(MAX_OUT)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .ce_i          (ce),
    .inc_i         (accept & iss_long),
    .set_i         (accept & iss_long & iss_use_rd),
    .set_rd_i      (iss_rd),
    .hs_i          (lng_hs),
    .hs_rd_i       (lng_rd),
    .alu_wr_i      (alu_go),
    .alu_rd_i      (alu_rd),
    .qa_i          (iss_ra),
    .qb_i          (iss_rb),
    .qd_i          (iss_rd),
    .pend_a_o      (pend_a),
    .pend_b_o      (pend_b),
    .pend_d_o      (pend_d),
    .full_o        (full),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

`ifdef RISC5_WB_FWD_EN
  // A matching long result this cycle feeds the operand directly.
  assign fwd_a = lng_hs & iss_use_ra & pend_a & (lng_rd == iss_ra);
  assign fwd_b = lng_hs & iss_use_rb & pend_b & (lng_rd == iss_rb);
  assign haz_a = iss_use_ra & pend_a & ~fwd_a;
  assign haz_b = iss_use_rb & pend_b & ~fwd_b;
`else
  assign haz_a = iss_use_ra & pend_a;
  assign haz_b = iss_use_rb & pend_b;
`endif
  // Destination hazard (WAW) also guarantees set/clear never collide.
  assign haz_d    = iss_use_rd & pend_d;
  assign throttle = (starve_q >= STARVE_W'(STARVE_LIM)) & ~iss_long;

  assign iss_stall = ~rst | (iss_valid & (haz_a | haz_b | haz_d |
                                          (iss_long & full) | throttle));
  assign accept    = iss_valid & ~iss_stall & ce;

  // Starve counter: consecutive cycles a long result loses to the ALU.
  always_comb begin
    starve_d = starve_q;
    if (!lng_valid || lng_hs)
      starve_d = '0;
    else if (alu_wr && starve_q < STARVE_W'(STARVE_LIM))
      starve_d = starve_q + 1'b1;
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    starve_q <= '0;
    else if (ce) starve_q <= starve_d;
  end
endmodule

// File: tb/tb_risc5_wb_sequencer.sv
// Directed bench for risc5_wb_sequencer; write-port results are checked
// against a queue of expected {wno, din} pairs filled as stimulus is driven.
module tb_risc5_wb_sequencer;
  logic        clk = 1'b0;
  logic        rst, ce;
  logic        iss_valid, iss_use_ra, iss_use_rb, iss_use_rd, iss_long;
  logic [3:0]  iss_ra, iss_rb, iss_rd;
  logic        iss_stall;
  logic        alu_wr;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lng_valid;
  logic [3:0]  lng_rd;
  logic [31:0] lng_data;
  logic        lng_ready, rf_wr;
  logic [3:0]  rf_wno;
  logic [31:0] rf_din;
  logic [3:0]  outstanding;
  logic        err;
`ifdef RISC5_WB_FWD_EN
  logic        fwd_a, fwd_b;
`endif

  int checks   = 0;
  int failures = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  risc5_wb_sequencer #(.MAX_OUT(4), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .iss_valid(iss_valid), .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rd(iss_rd),
    .iss_use_ra(iss_use_ra), .iss_use_rb(iss_use_rb), .iss_use_rd(iss_use_rd),
    .iss_long(iss_long), .iss_stall(iss_stall),
    .alu_wr(alu_wr), .alu_rd(alu_rd), .alu_data(alu_data),
    .lng_valid(lng_valid), .lng_rd(lng_rd), .lng_data(lng_data),
    .lng_ready(lng_ready),
    .rf_wr(rf_wr), .rf_wno(rf_wno), .rf_din(rf_din),
    .outstanding(outstanding), .err(err)
`ifdef RISC5_WB_FWD_EN
    , .fwd_a(fwd_a), .fwd_b(fwd_b)
`endif
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write seen on the port must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_wr === 1'b1) begin
      if (exp_q.size() == 0) chk("rf_unexpected_write", {rf_wno, rf_din}, 36'hF_FFFF_FFFF ^ {rf_wno, rf_din});
      else chk("rf_port", {rf_wno, rf_din}, exp_q.pop_front());
    end
  end

  task automatic idle();
    iss_valid = 0; iss_use_ra = 0; iss_use_rb = 0; iss_use_rd = 0; iss_long = 0;
    iss_ra = 0; iss_rb = 0; iss_rd = 0;
    alu_wr = 0; alu_rd = 0; alu_data = 0;
    lng_valid = 0; lng_rd = 0; lng_data = 0;
    ce = 1;
  endtask

  task automatic iss(input bit lng, input bit ua, input logic [3:0] ra,
                     input bit ud, input logic [3:0] rd);
    iss_valid = 1; iss_long = lng; iss_use_ra = ua; iss_ra = ra;
    iss_use_rb = 0; iss_rb = 0; iss_use_rd = ud; iss_rd = rd;
  endtask

  task automatic lng(input logic [3:0] rd, input logic [31:0] d, input bit expect_wr);
    lng_valid = 1; lng_rd = rd; lng_data = d;
    if (expect_wr) exp_q.push_back({rd, d});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with a long result waiting
    rst = 0; idle(); lng(4'd5, 32'h22, 0);
    #3;
    chk("rst_lng_ready", lng_ready, 0);
    chk("rst_rf_wr", rf_wr, 0);
    chk("rst_stall", iss_stall, 1);
    tick(); tick();
    rst = 1; idle(); #2;
    chk("rel_outstanding", outstanding, 0);
    chk("rel_err", err, 0);
    chk("rel_stall", iss_stall, 0);
    tick();

    // Collision: ALU R3 and long R5 in the same cycle
    idle(); iss(1, 0, 0, 1, 4'd5); #2;
    chk("lng_iss_r5_stall", iss_stall, 0);
    tick();
    idle(); alu_wr = 1; alu_rd = 3; alu_data = 32'h11; exp_q.push_back({4'd3, 32'h11});
    lng(4'd5, 32'h22, 0); #2;
    chk("coll_lng_ready", lng_ready, 0);
    chk("coll_rf", {rf_wr, rf_wno, rf_din}, {1'b1, 4'd3, 32'h11});
    tick();
    idle(); lng(4'd5, 32'h22, 1); #2;
    chk("coll2_lng_ready", lng_ready, 1);
    tick();
    idle(); iss(0, 1, 4'd5, 0, 0); #2;
    chk("coll_pend5_clear", iss_stall, 0);
    chk("coll_outstanding", outstanding, 0);
    tick();

    // RAW on R2
    idle(); iss(1, 0, 0, 1, 4'd2); #2;
    chk("raw_long_acc", iss_stall, 0);
    tick();
    idle(); iss(0, 1, 4'd2, 1, 4'd6); #2;
    chk("raw_stall", iss_stall, 1);
    tick();
    idle(); iss(0, 1, 4'd2, 1, 4'd6); lng(4'd2, 32'h33, 1); #2;
`ifdef RISC5_WB_FWD_EN
    chk("raw_wb_cycle_stall", iss_stall, 0);
    chk("raw_fwd_a", fwd_a, 1);
`else
    chk("raw_wb_cycle_stall", iss_stall, 1);
`endif
    tick();
    idle(); iss(0, 1, 4'd2, 1, 4'd6); #2;
    chk("raw_after_wb", iss_stall, 0);
    tick();

    // Full: four long ops outstanding
    for (int r = 1; r <= 4; r++) begin
      idle(); iss(1, 0, 0, 1, 4'(r)); #2;
      chk("full_fill_stall", iss_stall, 0);
      tick();
    end
    idle(); iss(1, 0, 0, 1, 4'd8); #2;
    chk("full_stall", iss_stall, 1);
    chk("full_outstanding", outstanding, 4);
    tick();
    idle(); iss(0, 0, 0, 1, 4'd3); #2;
    chk("waw_stall", iss_stall, 1);
    tick();
    idle(); iss(1, 0, 0, 1, 4'd8); lng(4'd1, 32'h44, 1); #2;
    chk("full_wb_cycle_stall", iss_stall, 1);
    tick();
    idle(); iss(1, 0, 0, 1, 4'd8); #2;
    chk("full_5th_acc", iss_stall, 0);
    chk("full_out3", outstanding, 3);
    tick();
    idle(); #2;
    chk("full_out4", outstanding, 4);
    tick();
    for (int r = 2; r <= 5; r++) begin
      idle(); lng((r == 5) ? 4'd8 : 4'(r), 32'h100 + r, 1); tick();
    end
    idle(); #2;
    chk("drain_outstanding", outstanding, 0);
    chk("drain_err", err, 0);
    tick();

    // Starvation of the long unit by back-to-back ALU writes
    idle(); iss(1, 0, 0, 1, 4'd9); tick();
    for (int i = 1; i <= 10; i++) begin
      idle(); iss(0, 0, 0, 0, 0);
      alu_wr = 1; alu_rd = 10; alu_data = 32'(i); exp_q.push_back({4'd10, 32'(i)});
      lng(4'd9, 32'h99, 0); #2;
      chk("starve_stall", iss_stall, (i >= 9) ? 1 : 0);
      chk("starve_lng_ready", lng_ready, 0);
      tick();
    end
    idle(); iss(0, 0, 0, 0, 0); lng(4'd9, 32'h99, 1); #2;
    chk("starve_drain_stall", iss_stall, 1);
    tick();
    idle(); iss(0, 0, 0, 0, 0); #2;
    chk("starve_cleared", iss_stall, 0);
    chk("starve_outstanding", outstanding, 0);
    tick();

    // Clock enable low: nothing written, nothing accepted
    idle(); ce = 0; iss(1, 0, 0, 1, 4'd12);
    alu_wr = 1; alu_rd = 12; alu_data = 32'h55; lng(4'd9, 32'h66, 0); #2;
    chk("ce0_rf_wr", rf_wr, 0);
    chk("ce0_lng_ready", lng_ready, 0);
    tick();
    idle(); iss(0, 1, 4'd12, 0, 0); #2;
    chk("ce0_no_accept", outstanding, 0);
    chk("ce0_no_pend", iss_stall, 0);
    chk("ce0_err", err, 0);
    tick();

    // Error: long result to a register nobody is waiting on
    idle(); lng(4'd7, 32'h77, 1); #2;
    chk("err_before", err, 0);
    tick();
    idle(); #2;
    chk("err_set", err, 1);
    tick(); tick();
    chk("err_sticky", err, 1);
    rst = 0; #1;
    chk("err_cleared_by_rst", err, 0);
    chk("err_rst_stall", iss_stall, 1);
    tick();
    rst = 1; tick();

    chk("queue_empty", 36'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
